// File: rtl/mesh_pkg.sv
// Shared mesh parameters and preload sequencer state encoding.
// Used by weight_preload_sequencer and its beat_serializer.
package mesh_pkg;

  localparam int DW     = 8;
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int ROW_W  = 3;
  localparam int COL_W  = 3;
  localparam int LANES  = 4;
  localparam int ADDR_W = ROW_W + COL_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIRE
  } preload_state_t;

endpackage

// File: rtl/weight_preload_sequencer_beat_serializer.sv
// Beat holding register and lane counter for the preload sequencer.
// The held beat is the one whose lane word is currently on the output.
import mesh_pkg::*;

module beat_serializer #(
  parameter int DW    = mesh_pkg::DW,
  parameter int LANES = mesh_pkg::LANES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [LANES*DW-1:0] s_data,
  output logic                word_valid,
  output logic [DW-1:0]       word,
  output logic                last,
  output logic                advance
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES*DW-1:0] hold;
  logic                hold_valid;
  logic [LW-1:0]       lane;
  logic [LW-1:0]       lane_nx;
  logic                fire;
  logic                step;

  assign last       = (lane == LW'(LANES - 1));
  assign s_ready    = en && (!hold_valid || last);
  assign fire       = s_valid && s_ready;
  assign step       = hold_valid && !last;
  assign advance    = fire || step;
  assign lane_nx    = lane + 1'b1;
  assign word_valid = hold_valid;

  // Capture a beat on handshake, then walk its lanes one per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      lane       <= '0;
      word       <= '0;
    end else if (clear) begin
      hold_valid <= 1'b0;
      lane       <= '0;
    end else if (fire) begin
      hold       <= s_data;
      hold_valid <= 1'b1;
      lane       <= '0;
      word       <= s_data[DW-1:0];
    end else if (step) begin
      lane       <= lane_nx;
      word       <= hold[int'(lane_nx)*DW +: DW];
    end else begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/weight_preload_sequencer.sv
// Serializes packed weight beats into mesh preload writes, then pulses start.
// Define PRELOAD_TRANSPOSE_EN for column-major address order.
import mesh_pkg::*;

module weight_preload_sequencer #(
  parameter int DW    = mesh_pkg::DW,
  parameter int ROWS  = mesh_pkg::ROWS,
  parameter int COLS  = mesh_pkg::COLS,
  parameter int ROW_W = mesh_pkg::ROW_W,
  parameter int COL_W = mesh_pkg::COL_W,
  parameter int LANES = mesh_pkg::LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_req,
  output logic                   busy,
  output logic                   done,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*DW-1:0]    s_data,
  output logic                   preload_valid,
  output logic [ROW_W+COL_W-1:0] preload_addr,
  output logic [DW-1:0]          preload_data,
  output logic                   start
);

  localparam int NBEATS = (ROWS * COLS) / LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  preload_state_t state, state_n;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [BW-1:0]    beat_cnt;
  logic             all_in;
  logic             start_load;
  logic             ser_en;
  logic             beat_fire;
  logic             word_valid;
  logic             last_lane;
  logic             advance;
  logic             row_end;
  logic             col_end;

  assign start_load = (state == IDLE) && load_req;
  assign ser_en     = (state == LOAD) && !all_in;
  assign beat_fire  = s_valid && s_ready;
  assign row_end    = (row == ROW_W'(ROWS - 1));
  assign col_end    = (col == COL_W'(COLS - 1));

  beat_serializer #(
    .DW    (DW),
    .LANES (LANES)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_load),
    .en         (ser_en),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .word_valid (word_valid),
    .word       (preload_data),
    .last       (last_lane),
    .advance    (advance)
  );

  assign preload_valid = word_valid;

  // Next-state: the load ends once the final lane of the final beat shows.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (load_req) state_n = LOAD;
      LOAD: if (word_valid && last_lane && all_in) state_n = FIRE;
      FIRE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register and registered busy/start/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      start <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      start <= (state_n == FIRE);
      done  <= (state_n == FIRE);
    end
  end

  // Count accepted beats so intake closes after the last one.
  always_ff @(posedge clk) begin
    if (rst || start_load) begin
      beat_cnt <= '0;
      all_in   <= 1'b0;
    end else if (beat_fire) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (beat_cnt == BW'(NBEATS - 1)) all_in <= 1'b1;
    end
  end

  // Element counters hold the next address; latch it as each word appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      row          <= '0;
      col          <= '0;
      preload_addr <= '0;
    end else if (start_load) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      preload_addr <= {row, col};
`ifdef PRELOAD_TRANSPOSE_EN
      if (row_end) begin
        row <= '0;
        col <= col + 1'b1;
      end else begin
        row <= row + 1'b1;
      end
`else
      if (col_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_weight_preload_sequencer.sv
// Directed bench for weight_preload_sequencer.
// Honors PRELOAD_TRANSPOSE_EN for expected addresses.
module tb_weight_preload_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic        busy;
  logic        done;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        preload_valid;
  logic [5:0]  preload_addr;
  logic [7:0]  preload_data;
  logic        start;

  int checks = 0;
  int errors = 0;

  logic [7:0] w [64];

  weight_preload_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .load_req      (load_req),
    .busy          (busy),
    .done          (done),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .preload_valid (preload_valid),
    .preload_addr  (preload_addr),
    .preload_data  (preload_data),
    .start         (start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       load_req;
    logic       s_valid;
    logic       busy;
    logic       s_ready;
    logic       pv;
    logic [5:0] addr;
    logic [7:0] data;
    logic       start;
    logic       done;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [5:0] ea(input int k);
`ifdef PRELOAD_TRANSPOSE_EN
    return {3'(k % 8), 3'(k / 8)};
`else
    return 6'(k);
`endif
  endfunction

  function automatic vec_t mk(
    input logic r, input logic lr, input logic sv,
    input logic b, input logic rdy, input logic pv,
    input logic [5:0] a, input logic [7:0] d);
    vec_t v;
    v.rst = r; v.load_req = lr; v.s_valid = sv;
    v.busy = b; v.s_ready = rdy; v.pv = pv;
    v.addr = a; v.data = d; v.start = 1'b0; v.done = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] outs();
    return {busy, done, s_ready, preload_valid, preload_addr,
            preload_data, start};
  endfunction

  task automatic do_load(input int mode, input int abort_at,
                         input bit poke);
    int  nwr = 0;
    int  beat = 0;
    int  first = 0;
    int  lastc = 0;
    int  idx;
    bit  fin = 1'b0;
    bit  prev_pv = 1'b0;
    bit  hs;
    load_req = 1'b1;
    s_valid  = 1'b0;
    step();
    load_req = 1'b0;
    chk("accept_busy_ready", {busy, s_ready}, 2'b11);
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      s_valid = (beat < 16) &&
                (mode == 0 || cyc % 4 == 0 || cyc % 4 == 3);
      for (int l = 0; l < 4; l++)
        s_data[l*8 +: 8] = (beat < 16) ? w[beat*4 + l] : 8'h00;
      load_req = poke && (cyc == 10);
      hs = s_valid && s_ready;
      step();
      if (hs) beat++;
      if (preload_valid) begin
        idx = (nwr < 64) ? nwr : 63;
        chk("addr", preload_addr, ea(idx));
        chk("data", preload_data, w[idx]);
        if (nwr == 0) first = cyc;
        lastc = cyc;
        nwr++;
        if (abort_at > 0 && nwr == abort_at) begin
          rst = 1'b1;
          s_valid = 1'b0;
          step();
          chk("reset_outputs_zero", outs(), '0);
          rst = 1'b0;
          for (int j = 0; j < 3; j++) begin
            step();
            chk("no_start_after_reset", {busy, start, done}, 3'b000);
          end
          fin = 1'b1;
        end
      end else if (start) begin
        chk("start_follows_last_write", prev_pv, 1'b1);
        chk("write_count", nwr, 64);
        chk("done_with_start", done, 1'b1);
        if (mode == 0) chk("continuous_span", lastc - first, 63);
        step();
        chk("busy_drop", {busy, start, done}, 3'b000);
        fin = 1'b1;
      end
      prev_pv = preload_valid;
    end
    s_valid  = 1'b0;
    load_req = 1'b0;
    chk("no_timeout", fin, 1'b1);
    if (poke) begin
      for (int j = 0; j < 4; j++) begin
        step();
        chk("single_start", {busy, start, preload_valid}, 3'b000);
      end
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 6'h0, 8'h00);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 6'h0, 8'h00);
    tbl[2]  = mk(0, 0, 1, 0, 0, 0, 6'h0, 8'h00);
    tbl[3]  = mk(0, 0, 1, 0, 0, 0, 6'h0, 8'h00);
    tbl[4]  = mk(0, 0, 1, 0, 0, 0, 6'h0, 8'h00);
    tbl[5]  = mk(0, 1, 0, 1, 1, 0, 6'h0, 8'h00);
    tbl[6]  = mk(0, 0, 1, 1, 0, 1, ea(0), 8'hA0);
    tbl[7]  = mk(0, 0, 0, 1, 0, 1, ea(1), 8'h5F);
    tbl[8]  = mk(0, 0, 0, 1, 0, 1, ea(2), 8'h80);
    tbl[9]  = mk(0, 0, 0, 1, 1, 1, ea(3), 8'h7F);
    tbl[10] = mk(0, 0, 0, 1, 1, 0, ea(3), 8'h7F);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 6'h0, 8'h00);

    s_data = {8'h7F, 8'h80, 8'h5F, 8'hA0};
    for (int i = 0; i < 12; i++) begin
      rst      = tbl[i].rst;
      load_req = tbl[i].load_req;
      s_valid  = tbl[i].s_valid;
      step();
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].busy, tbl[i].done, tbl[i].s_ready, tbl[i].pv,
           tbl[i].addr, tbl[i].data, tbl[i].start});
    end

    rst      = 1'b0;
    load_req = 1'b0;
    s_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_quiet", outs(), '0);
    end
    s_valid = 1'b0;

    for (int k = 0; k < 64; k++) w[k] = 8'(k);
    do_load(0, 0, 1'b0);

    w[5] = 8'h80;
    w[6] = 8'h7F;
    w[40] = 8'hFF;
    do_load(1, 0, 1'b0);

    for (int k = 0; k < 64; k++) w[k] = 8'(k + 100);
    do_load(0, 0, 1'b1);

    do_load(0, 21, 1'b0);

    for (int k = 0; k < 64; k++) w[k] = 8'(255 - k);
    do_load(1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
